// File: rtl/tape_pkg.sv
// Shared definitions for the tape controller: symbol codes, tape op encodings,
// control FSM states, rule entry layout and the symbol-class helper.
// Optional feature macro: TAPE_CTRL_SINGLE_STEP_EN (adds the PAUSE state).
package tape_pkg;

   // Tape symbols
   localparam logic [1:0] SYM_ZERO  = 2'b00;
   localparam logic [1:0] SYM_ONE   = 2'b01;
   localparam logic [1:0] SYM_BLANK = 2'b10;

   // Tape operations
   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SHL   = 2'b10;
   localparam logic [1:0] OP_SHR   = 2'b11;

   // Control FSM states
   typedef enum logic [2:0] {
      CTRL_IDLE,
      CTRL_FETCH,
      CTRL_WAIT,
      CTRL_WRITE,
      CTRL_MOVE,
      CTRL_HALT
`ifdef TAPE_CTRL_SINGLE_STEP_EN
      , CTRL_PAUSE
`endif
   } ctrl_t;

   // Rule entry layout: {next_state, write_sym[1:0], move, halt}
   localparam int unsigned RULE_HALT_BIT = 0;
   localparam int unsigned RULE_MOVE_BIT = 1;
   localparam int unsigned RULE_WSYM_LSB = 2;
   localparam int unsigned RULE_NS_LSB   = 4;

   // Low field bits of the reset entry: write 0, shift right, halt
   localparam logic [3:0] RULE_DEFAULT = 4'b0001;

   // Map a tape symbol to its rule class: 0 -> 0, 1 -> 1, blank -> 2
   function automatic logic [1:0] sym_class(input logic [1:0] sym);
      return sym[1] ? 2'd2 : {1'b0, sym[0]};
   endfunction

endpackage

// File: rtl/tape_rule_table.sv
// Programmable rule table for the tape controller.
// Ports: clk, reset (sync, active-high), we/waddr/wdata write port,
//        raddr/rdata combinational read port.
// Every entry resets to the default halt entry.
module tape_rule_table
   import tape_pkg::*;
#(
   parameter int unsigned STATE_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [STATE_W+1:0]   waddr,
   input  logic [STATE_W+3:0]   wdata,
   input  logic [STATE_W+1:0]   raddr,
   output logic [STATE_W+3:0]   rdata
);

   localparam int unsigned DATA_W = STATE_W + 4;
   localparam int unsigned DEPTH  = 1 << (STATE_W + 2);

   logic [DATA_W-1:0] entries [DEPTH];

   // Register file with synchronous reset to the halt entry
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i] <= DATA_W'(RULE_DEFAULT);
         end
      end else if (we) begin
         entries[waddr] <= wdata;
      end
   end

   assign rdata = entries[raddr];

endmodule

// File: rtl/tape_controller.sv
// Turing tape controller: reads the symbol under the head, looks up a rule,
// writes a symbol and shifts the head, counting steps up to MAX_STEPS.
// Ports: clk, reset (sync, active-high); start / rule_we / rule_addr / rule_data
//        from the board; tape_req / tape_op / tape_wdata / tape_rdata to the tape;
//        busy / halted / timeout / step_count / cur_state status.
// Optional feature macro: TAPE_CTRL_SINGLE_STEP_EN adds input step_en and a
// PAUSE state between steps.
module tape_controller
   import tape_pkg::*;
#(
   parameter int unsigned STATE_W   = 3,
   parameter int unsigned MAX_STEPS = 255,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
`ifdef TAPE_CTRL_SINGLE_STEP_EN
   input  logic                 step_en,
`endif
   input  logic                 rule_we,
   input  logic [STATE_W+1:0]   rule_addr,
   input  logic [STATE_W+3:0]   rule_data,
   output logic                 tape_req,
   output logic [1:0]           tape_op,
   output logic [1:0]           tape_wdata,
   input  logic [1:0]           tape_rdata,
   output logic                 busy,
   output logic                 halted,
   output logic                 timeout,
   output logic [CNT_W-1:0]     step_count,
   output logic [STATE_W-1:0]   cur_state
);

   localparam int unsigned ADDR_W = STATE_W + 2;
   localparam int unsigned DATA_W = STATE_W + 4;

   ctrl_t               ctrl;
   logic [STATE_W-1:0]  ns_q;
   logic                move_q;
   logic                halt_q;

   logic                idle_c;
   logic                rule_we_ok_c;
   logic [ADDR_W-1:0]   rd_addr_c;
   logic [DATA_W-1:0]   rd_data_c;
   logic [CNT_W-1:0]    step_inc_c;
   logic [CNT_W-1:0]    step_sat_c;

   // Table writes only while not running
   assign idle_c       = (ctrl == CTRL_IDLE) || (ctrl == CTRL_HALT);
   assign rule_we_ok_c = rule_we & idle_c;
   assign rd_addr_c    = {cur_state, sym_class(tape_rdata)};

   // Step counter increment, saturating at MAX_STEPS
   assign step_inc_c = step_count + CNT_W'(1);
   assign step_sat_c = (step_count == CNT_W'(MAX_STEPS)) ? step_count : step_inc_c;

   tape_rule_table #(
      .STATE_W (STATE_W)
   ) u_rule_table (
      .clk   (clk),
      .reset (reset),
      .we    (rule_we_ok_c),
      .waddr (rule_addr),
      .wdata (rule_data),
      .raddr (rd_addr_c),
      .rdata (rd_data_c)
   );

   // Control FSM; outputs are registered alongside the state they belong to
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl       <= CTRL_IDLE;
         tape_req   <= 1'b0;
         tape_op    <= OP_READ;
         tape_wdata <= SYM_ZERO;
         busy       <= 1'b0;
         halted     <= 1'b0;
         timeout    <= 1'b0;
         step_count <= '0;
         cur_state  <= '0;
         ns_q       <= '0;
         move_q     <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         tape_req   <= 1'b0;
         tape_op    <= OP_READ;
         tape_wdata <= SYM_ZERO;
         case (ctrl)
            CTRL_IDLE, CTRL_HALT: begin
               if (start) begin
                  ctrl       <= CTRL_FETCH;
                  tape_req   <= 1'b1;
                  busy       <= 1'b1;
                  halted     <= 1'b0;
                  timeout    <= 1'b0;
                  step_count <= '0;
                  cur_state  <= '0;
               end
            end
            CTRL_FETCH: begin
               ctrl <= CTRL_WAIT;
            end
            CTRL_WAIT: begin
               // tape_rdata is valid now; capture the selected rule
               ctrl       <= CTRL_WRITE;
               tape_req   <= 1'b1;
               tape_op    <= OP_WRITE;
               tape_wdata <= rd_data_c[RULE_WSYM_LSB +: 2];
               ns_q       <= rd_data_c[RULE_NS_LSB +: STATE_W];
               move_q     <= rd_data_c[RULE_MOVE_BIT];
               halt_q     <= rd_data_c[RULE_HALT_BIT];
            end
            CTRL_WRITE: begin
               if (halt_q) begin
                  ctrl       <= CTRL_HALT;
                  busy       <= 1'b0;
                  halted     <= 1'b1;
                  step_count <= step_sat_c;
               end else begin
                  ctrl     <= CTRL_MOVE;
                  tape_req <= 1'b1;
                  tape_op  <= move_q ? OP_SHL : OP_SHR;
               end
            end
            CTRL_MOVE: begin
               cur_state  <= ns_q;
               step_count <= step_sat_c;
               if (step_inc_c == CNT_W'(MAX_STEPS)) begin
                  ctrl    <= CTRL_HALT;
                  busy    <= 1'b0;
                  halted  <= 1'b1;
                  timeout <= 1'b1;
               end else begin
`ifdef TAPE_CTRL_SINGLE_STEP_EN
                  ctrl <= CTRL_PAUSE;
`else
                  ctrl     <= CTRL_FETCH;
                  tape_req <= 1'b1;
`endif
               end
            end
`ifdef TAPE_CTRL_SINGLE_STEP_EN
            CTRL_PAUSE: begin
               if (step_en) begin
                  ctrl     <= CTRL_FETCH;
                  tape_req <= 1'b1;
               end
            end
`endif
            default: begin
               ctrl <= CTRL_IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
